// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: drives one RGB LED from a 24-bit colour word with 8-bit PWM per channel.
//
// A prescaler divides clk by PRESCALE to step an 8-bit PWM counter, so one PWM period lasts
// 256*PRESCALE clk cycles. The three duty registers are double-buffered: while running they
// are reloaded from rgb only when the counter wraps, so a colour change never produces a
// partial or glitched period. All outputs are registered; there is no combinational path from
// any input to any output.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, highest priority
//   enable       run PWM when high; when low LEDs are off, counters held at 0 and the duty
//                registers track rgb so the first period after enable uses the current colour
//   rgb          colour word: [23:16] red, [15:8] green, [7:0] blue duty
//   led_r/g/b    registered LED drives
//   period_start one-cycle pulse at the start of each PWM period (new duties in effect)

module rgb_led_pwm #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_start
);

    // Keep the prescaler at least one bit wide so PRESCALE=1 stays legal.
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_cnt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty_r;
    logic [7:0]    duty_g;
    logic [7:0]    duty_b;

    logic tick;
    logic wrap;
    logic cmp_r;
    logic cmp_g;
    logic cmp_b;

    always_comb begin
        tick = (presc_cnt == PRESC_MAX);
        wrap = tick && (pwm_cnt == 8'hFF);
        // Full scale is forced high so 0xFF has no low cycle at the wrap.
        cmp_r = (duty_r == 8'hFF) || (pwm_cnt < duty_r);
        cmp_g = (duty_g == 8'hFF) || (pwm_cnt < duty_g);
        cmp_b = (duty_b == 8'hFF) || (pwm_cnt < duty_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            pwm_cnt      <= 8'd0;
            duty_r       <= 8'd0;
            duty_g       <= 8'd0;
            duty_b       <= 8'd0;
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
            period_start <= 1'b0;
        end else if (!enable) begin
            presc_cnt    <= '0;
            pwm_cnt      <= 8'd0;
            // Track the input while idle so the first enabled period uses the live colour.
            duty_r       <= rgb[23:16];
            duty_g       <= rgb[15:8];
            duty_b       <= rgb[7:0];
            led_r        <= 1'b0;
            led_g        <= 1'b0;
            led_b        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (wrap) begin
                duty_r <= rgb[23:16];
                duty_g <= rgb[15:8];
                duty_b <= rgb[7:0];
            end
            period_start <= wrap;
            // Compare against the pre-edge counter and duties, so pins lag the state by one
            // cycle and the new period appears the cycle after period_start.
            led_r <= cmp_r;
            led_g <= cmp_g;
            led_b <= cmp_b;
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Bench for rgb_led_pwm: a PRESCALE=2 and a PRESCALE=1 instance share stimulus. A time-based
// model (enabled-edge count -> position in period) is compared every cycle, and directed
// sequences count high cycles per window against hand-computed figures.

module tb_rgb_led_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] rgb;
    logic        led_r2, led_g2, led_b2, ps2;
    logic        led_r1, led_g1, led_b1, ps1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rgb_led_pwm #(.PRESCALE(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .rgb(rgb),
        .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .period_start(ps2)
    );

    rgb_led_pwm #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .rgb(rgb),
        .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .period_start(ps1)
    );

    // Model: n = enabled edges since counters were last cleared; the counter value seen by an
    // edge is (n/P) mod 256, a period ends when n is a multiple of 256*P.
    int          n_en [2];
    logic [23:0] mduty[2];
    logic [3:0]  exp_o[2];
    bit          started = 1'b0;
    int          mp, mpwm;
    logic [7:0]  md;

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            mp = (s == 0) ? 2 : 1;
            if (rst) begin
                n_en[s]  = 0;
                mduty[s] = 24'h0;
                exp_o[s] = 4'b0000;
            end else if (!enable) begin
                n_en[s]  = 0;
                mduty[s] = rgb;
                exp_o[s] = 4'b0000;
            end else begin
                mpwm = (n_en[s] / mp) % 256;
                for (int c = 0; c < 3; c++) begin
                    md = mduty[s][(2-c)*8 +: 8];
                    exp_o[s][3-c] = (md == 8'hFF) || (mpwm < int'(md));
                end
                n_en[s]++;
                exp_o[s][0] = ((n_en[s] % (256 * mp)) == 0);
                if (exp_o[s][0]) mduty[s] = rgb;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            total++;
            if ({led_r2, led_g2, led_b2, ps2} !== exp_o[0]) begin
                bad++;
                $display("FAIL cycle_p2 t=%0t: got %b expected %b", $time,
                         {led_r2, led_g2, led_b2, ps2}, exp_o[0]);
            end
            total++;
            if ({led_r1, led_g1, led_b1, ps1} !== exp_o[1]) begin
                bad++;
                $display("FAIL cycle_p1 t=%0t: got %b expected %b", $time,
                         {led_r1, led_g1, led_b1, ps1}, exp_o[1]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    function automatic logic [3:0] outs(input int sel);
        return (sel == 0) ? {led_r2, led_g2, led_b2, ps2} : {led_r1, led_g1, led_b1, ps1};
    endfunction

    // Advance len edges on one instance, counting high cycles per LED and period_start pulses,
    // then compare with the expected figures (efirst < 0 skips the first-edge LED check).
    task automatic period_chk(input string nm, input int sel, input int len, input int er,
                              input int eg, input int eb, input int epc, input int epl,
                              input int efirst);
        int hr = 0, hg = 0, hb = 0, pc = 0, pl = 0, first = 0;
        logic [3:0] o;
        for (int i = 0; i < len; i++) begin
            step(1);
            o = outs(sel);
            if (i == 0) first = int'(o[3:1]);
            hr += int'(o[3]);
            hg += int'(o[2]);
            hb += int'(o[1]);
            pc += int'(o[0]);
            if (i == len - 1) pl = int'(o[0]);
        end
        chk({nm, "_r_high"}, hr, er);
        chk({nm, "_g_high"}, hg, eg);
        chk({nm, "_b_high"}, hb, eb);
        chk({nm, "_ps_count"}, pc, epc);
        chk({nm, "_ps_last"}, pl, epl);
        if (efirst >= 0) chk({nm, "_first_leds"}, first, efirst);
    endtask

    initial begin
        int cyc, highs;
        logic [3:0] o;

        // Reset held 3 cycles with everything requesting full brightness.
        rst = 1'b1; enable = 1'b1; rgb = 24'hFFFFFF;
        step(3);
        chk("reset_outputs", int'(outs(0)), 0);
        rst = 1'b0;

        // First period after reset must stay dark and end 512 edges later.
        cyc = 0; highs = 0;
        do begin
            step(1);
            cyc++;
            o = outs(0);
            highs += int'(o[3]) + int'(o[2]) + int'(o[1]);
        end while (!o[0] && cyc < 600);
        chk("reset_first_ps_delay", cyc, 512);
        chk("reset_first_period_dark", highs, 0);
        period_chk("full_white", 0, 512, 512, 512, 512, 1, 1, 7);

        // Duty ratios from an enable rising edge; idle tracking makes the first period valid.
        enable = 1'b0;
        rgb = 24'h804000;
        step(5);
        enable = 1'b1;
        period_chk("ratio_p1", 0, 512, 256, 128, 0, 1, 1, 6);
        period_chk("ratio_p2", 0, 512, 256, 128, 0, 1, 1, -1);

        // Full and near-zero boundaries; the change lands on the following period.
        rgb = 24'hFF0001;
        period_chk("boundary_pre", 0, 512, 256, 128, 0, 1, 1, -1);
        period_chk("boundary_p1", 0, 512, 512, 0, 2, 1, 1, 5);
        period_chk("boundary_p2", 0, 512, 512, 0, 2, 1, 1, 5);

        // Mid-period update is ignored until the next wrap.
        rgb = 24'h000000;
        period_chk("mid_pre", 0, 512, 512, 0, 2, 1, 1, -1);
        period_chk("mid_head", 0, 100, 0, 0, 0, 0, 0, 0);
        rgb = 24'hFFFFFF;
        period_chk("mid_tail", 0, 412, 0, 0, 0, 1, 1, -1);
        period_chk("mid_after", 0, 512, 512, 512, 512, 1, 1, 7);

        // Enable dropped 300 cycles into a 50% period, then re-asserted.
        rgb = 24'h808080;
        period_chk("toggle_pre", 0, 512, 512, 512, 512, 1, 1, -1);
        period_chk("toggle_head", 0, 300, 256, 256, 256, 0, 0, 7);
        enable = 1'b0;
        period_chk("toggle_off", 0, 10, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        period_chk("toggle_on", 0, 512, 256, 256, 256, 1, 1, 7);

        // PRESCALE=1 instance: 256-cycle period, small duties.
        enable = 1'b0;
        rgb = 24'h010203;
        step(1);
        enable = 1'b1;
        period_chk("p1_a", 1, 256, 1, 2, 3, 1, 1, 7);
        period_chk("p1_b", 1, 256, 1, 2, 3, 1, 1, 7);

        // Reset while running clears duties: next period dark despite a live colour.
        rst = 1'b1;
        step(1);
        chk("rst_mid_outputs", int'(outs(0)), 0);
        rst = 1'b0;
        period_chk("rst_mid_dark", 1, 256, 0, 0, 0, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_led_pwm.md
Name: rgb_led_pwm

Overview:
- Downstream consumer of the RGB colour converter.
- Takes its 24-bit rgb word and drives one physical RGB LED (three pins) with 8-bit PWM per channel.
- Duty values are double-buffered and loaded only at PWM period boundaries, so colour changes never cause partial or glitched periods.
- Sits between the converter output and the board LED pins.

Parameters:
- PRESCALE, 4: number of clk cycles per PWM count step; must be >= 1. PWM period = 256*PRESCALE clk cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  run PWM when high; when low, LEDs off and counters held at 0
- rgb  input  24  colour word: [23:16] red duty, [15:8] green duty, [7:0] blue duty
- led_r  output  1  red LED drive, registered
- led_g  output  1  green LED drive, registered
- led_b  output  1  blue LED drive, registered
- period_start  output  1  one-cycle pulse marking the start of each PWM period (new duties effective)

Behaviour:
- Reset, sampled on the clk edge, has priority over everything else: presc_cnt=0, pwm_cnt=0, duty_r/g/b=0, led_r/g/b=0, period_start=0.
- enable=0 (no reset):
  - presc_cnt=0, pwm_cnt=0, leds=0, period_start=0.
  - duty_r/g/b <= rgb every cycle, so the first period after enable uses the current rgb.
- enable=1, prescaler and counter:
  - tick = (presc_cnt == PRESCALE-1).
  - presc_cnt <= tick ? 0 : presc_cnt+1.
  - On tick, pwm_cnt (8-bit) <= pwm_cnt+1, wrapping 255->0.
- enable=1, period wrap:
  - wrap = tick && pwm_cnt==255.
  - On wrap: duty_r<=rgb[23:16], duty_g<=rgb[15:8], duty_b<=rgb[7:0], and period_start<=1.
  - Otherwise period_start<=0 and duties hold.
  - rgb changes between wraps are ignored.
- enable=1, outputs:
  - led_x <= (duty_x==8'hFF) | (pwm_cnt < duty_x), using the current registered pwm_cnt and duty_x.
  - Outputs lag the counter/duty state by one clk cycle.
  - The first cycle of a new period shows on the pins the cycle after period_start is high.
- Duty mapping:
  - 0x00: pin never high.
  - 0x01..0xFE: high for duty*PRESCALE cycles per period.
  - 0xFF: high for all 256*PRESCALE cycles, with no low cycle at the wrap.
- PRESCALE=1: tick every cycle, period 256 cycles; behaviour otherwise identical.
- enable falling mid-period: at the next edge, leds=0 and counters=0; no period_start is issued.
- enable rising: the first wrap (period_start high) occurs 256*PRESCALE edges after the first enabled edge, counting that edge.
- rst mid-operation: all state cleared at that edge, and duties become 0.
  - If enable=1 after reset, leds stay 0 for the whole first period.
  - rgb is first adopted at the first wrap.
- rst and enable together: rst wins.
- No combinational path from any input to any output.

Test Plan:
- Reset: PRESCALE=2, enable=1, rgb=24'hFFFFFF, rst high 3 cycles -> led_r/g/b=0 and period_start=0 during reset. After release, leds stay 0 until the first period_start 512 cycles later, then all three stay high.
- Duty ratios: PRESCALE=2, rgb=24'h804000, enable rises with rst low -> per 512-cycle period, led_r high 256 cycles, led_g 128, led_b 0. period_start exactly once per 512 cycles.
- Full/zero boundary: rgb=24'hFF0001 -> led_r high continuously across several periods, including the wrap; led_g always 0; led_b high exactly 2 cycles per period, immediately after the period start.
- Mid-period update: running with rgb=24'h000000, change to 24'hFFFFFF 100 cycles into a period -> all leds remain 0 until period_start. All leds go high on the cycle after period_start and stay high.
- Enable toggle: drop enable 300 cycles into a period with rgb=24'h808080 -> all leds 0 from the next cycle, and no period_start. Re-assert enable -> leds follow the 50% pattern immediately. Next period_start comes 512 cycles after the re-enable edge.
- PRESCALE=1 instance, rgb=24'h010203 -> period 256 cycles; led_r/g/b high 1/2/3 cycles per period.
